// File: rtl/instr_fetch_pkg.sv
// Shared fetch-path definitions: datapath width, default reset vector and the
// {pc, inst} record carried through the prefetch buffer.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch unit: instruction-memory port, redirect input and
// the decode-side handshake.
interface instr_fetch_if #(
  parameter int XLEN = 32
);

  // Decode handshake: an instruction transfers on every cycle where if_valid
  // and if_ready are both high. While if_valid is high and no transfer occurs,
  // if_pc/if_inst stay stable unless a redirect or reset flushes the buffer.
  // The memory port has no ready: each imem_req is answered by imem_rdata on
  // the very next cycle.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_inst
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_inst
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, inst} records with
// same-cycle push/pop, synchronous flush and asynchronous reset.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  fetch_entry_t            push_data,
  input  logic                    pop,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Flush wins over a same-cycle push: a response landing with a redirect is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency
// word reads and feeds decode from a small prefetch buffer.
module instr_fetch #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OCC_W = CW + 1;

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        pend_pc;
  logic                   inflight;
  logic                   kill;
  logic [CW-1:0]          fifo_count;
  logic                   pop;
  logic                   push;
  logic [OCC_W-1:0]       occupancy;
  riscv_pkg::fetch_entry_t push_entry;
  riscv_pkg::fetch_entry_t head;

  assign pop = bus.if_valid && bus.if_ready;

  // Slots already committed once this cycle's pop leaves; a new request is
  // only allowed when its response is guaranteed a free entry.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight) - OCC_W'(pop);

  assign bus.imem_req  = !rst && !bus.redirect_valid && (occupancy < OCC_W'(DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign push = inflight && !kill;

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = pend_pc;
    push_entry.inst = bus.imem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= bus.imem_req;
      kill     <= bus.redirect_valid;
      if (bus.redirect_valid) begin
        fetch_pc <= riscv_pkg::word_align(bus.redirect_pc);
      end else if (bus.imem_req) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.if_valid = (fifo_count != '0);
  assign bus.if_pc    = head.pc;
  assign bus.if_inst  = head.inst;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle-level reference model of the
// fetch stream plus directed literal checks of reset, stall, redirect and wrap.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int          W     = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(W)) bus ();
  instr_fetch_if #(.XLEN(W)) bus2 ();

  instr_fetch #(.XLEN(W), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(.XLEN(W), .RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] salt = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a, input logic [31:0] s);
    return a ^ s;
  endfunction

  // Garbage on cycles without a request exposes any push of an unrequested word.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req ? mem_f(bus.imem_addr, salt) : $urandom;
    bus2.imem_rdata <= bus2.imem_addr;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];
  bit             m_infl;
  bit             m_kill;
  logic [W-1:0]   m_infl_pc;
  logic [W-1:0]   m_infl_inst;
  logic [W-1:0]   m_npc;

  logic         last_req, last_valid, last2_req;
  logic [W-1:0] last_addr, last_pc, last_inst, last2_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    exp_q.delete();
    m_infl = 1'b0;
    m_kill = 1'b0;
    m_npc  = rpc;
  endtask

  // One clock cycle: drive inputs, sample outputs, compare with the model,
  // advance the model by the rules of issue / response / redirect.
  task automatic tick(input bit r, input bit rv, input logic [31:0] rpc);
    bit pop;
    bit ereq;
    int occ;
    bus.if_ready       = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    last_req   = bus.imem_req;
    last_addr  = bus.imem_addr;
    last_valid = bus.if_valid;
    last_pc    = bus.if_pc;
    last_inst  = bus.if_inst;
    last2_req  = bus2.imem_req;
    last2_addr = bus2.imem_addr;

    pop  = (exp_q.size() != 0) && r;
    occ  = int'(exp_q.size()) + int'(m_infl) - int'(pop);
    ereq = !rv && (occ < DEPTH);

    chk("if_valid", 32'(last_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("if_pc", last_pc, exp_q[0][2*W-1:W]);
      chk("if_inst", last_inst, exp_q[0][W-1:0]);
    end
    chk("imem_req", 32'(last_req), 32'(ereq));
    if (ereq) chk("imem_addr", last_addr, m_npc);
    chk("fifo_count", 32'(dut.fifo_count), 32'(exp_q.size()));

    if (pop) void'(exp_q.pop_front());
    if (rv) begin
      exp_q.delete();
      m_npc = {rpc[31:2], 2'b00};
    end else if (m_infl && !m_kill) begin
      exp_q.push_back({m_infl_pc, m_infl_inst});
    end
    if (ereq) begin
      m_infl_pc   = m_npc;
      m_infl_inst = mem_f(m_npc, salt);
      m_npc       = m_npc + 32'd4;
    end
    m_infl = ereq;
    m_kill = rv;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int req_cnt;
    logic [31:0] exp2 [3];
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;

    bus.if_ready        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus2.if_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_inst", bus.if_inst, 32'd0);
    chk("rst_imem_req2", 32'(bus2.imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(32'h0);

    // Stall from reset: exactly DEPTH requests, then release delivers 0,4,8.
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, '0);
      req_cnt += int'(last_req);
      if (i < 3) chk("wrap_addr", last2_addr, exp2[i]);
    end
    chk("stall_req_count", 32'(req_cnt), 32'd2);
    chk("stall_req_low", 32'(last_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, '0);
      chk("release_valid", 32'(last_valid), 32'd1);
      chk("release_pc", last_pc, 32'(4 * i));
      if (i == 0) chk("release_req", 32'(last_req), 32'd1);
    end
    repeat (3) tick(1'b1, 1'b0, '0);

    // Redirect to an unaligned target in steady state.
    tick(1'b1, 1'b1, 32'h0000_0103);
    chk("redir_no_req", 32'(last_req), 32'd0);
    tick(1'b1, 1'b0, '0);
    chk("redir_req", 32'(last_req), 32'd1);
    chk("redir_addr", last_addr, 32'h0000_0100);
    tick(1'b1, 1'b0, '0);
    chk("redir_empty", 32'(last_valid), 32'd0);
    tick(1'b1, 1'b0, '0);
    chk("redir_valid", 32'(last_valid), 32'd1);
    chk("redir_pc", last_pc, 32'h0000_0100);
    chk("redir_inst", last_inst, 32'h0000_0100);

    // Redirect with a simultaneous accept.
    repeat (2) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h0000_0200);
    chk("redir_pop_valid", 32'(last_valid), 32'd1);
    repeat (3) tick(1'b1, 1'b0, '0);
    chk("redir_pop_pc", last_pc, 32'h0000_0200);

    // Randomized traffic against the model, with occasional wrap-around targets.
    salt = 32'h5A5A_1234;
    for (int i = 0; i < 1500; i++) begin
      bit rdy;
      bit rv;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick(rdy, rv, tgt);
    end

    // Reset mid-operation with buffered and in-flight data.
    salt = 32'h0;
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("midrst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_count", 32'(dut.fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(32'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, '0);
      if (i < 3) chk("restart_addr", last_addr, 32'(4 * i));
      if (i < 2) chk("restart_empty", 32'(last_valid), 32'd0);
      if (i >= 2) begin
        chk("restart_pc", last_pc, 32'(4 * (i - 2)));
        chk("restart_inst", last_inst, 32'(4 * (i - 2)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
